// File: rtl/crc_gen_param_pkg.sv
// Shared CRC definitions: FSM state encoding, standard polynomials and the
// STEP-bit unrolled MSB-first LFSR update used by the engine.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [7:0]  CRC8        = 8'h07;
    localparam logic [31:0] CRC32       = 32'h04C11DB7;

    // Folds step bits (bits[step-1] first) into a crc_w-wide register.
    // Widths are carried at their maxima (32-bit CRC, 16-bit step) and
    // masked, so one function serves every instance.
    function automatic logic [31:0] crc_step(
        input logic [31:0]  crc,
        input logic [15:0]  bits,
        input logic [31:0]  poly,
        input int unsigned  crc_w,
        input int unsigned  step
    );
        logic [31:0] c;
        logic [31:0] mask;
        logic [4:0]  msb;
        logic [3:0]  idx;
        logic        fb;
        c    = crc;
        mask = (crc_w >= 32) ? '1 : ((32'd1 << crc_w) - 32'd1);
        msb  = 5'(crc_w - 1);
        for (int unsigned k = 0; k < 16; k++) begin
            if (k < step) begin
                idx = 4'(step - 1 - k);
                fb  = c[msb] ^ bits[idx];
                c   = (c << 1) & mask;
                if (fb) c = c ^ (poly & mask);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_gen_param.sv
// Iterative CRC generator/checker: accepts one {payload, crc} word, folds
// STEP payload bits per clock, then holds {payload, crc} and a check flag.
module crc_gen_param
    import crc_pkg::*;
#(
    parameter int unsigned      DATA_W = 176,
    parameter int unsigned      CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_CCITT),
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter int unsigned      STEP   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic [DATA_W+CRC_W-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W+CRC_W-1:0] data_out,
    output logic [CRC_W-1:0]        crc_out,
    output logic                    crc_ok,
    output logic                    busy
);

    localparam int unsigned N     = DATA_W / STEP;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   shreg;
    logic [CRC_W-1:0]    crc_reg;
    logic [CRC_W-1:0]    rx_crc;
    logic                mode_r;

    logic [CRC_W-1:0]    crc_next;
    logic [2*DATA_W-1:0] rot;
    logic [DATA_W-1:0]   shreg_next;

    // The payload register rotates rather than shifts, so after N steps it
    // holds the original payload again and no separate copy is needed.
    always_comb begin
        crc_next   = CRC_W'(crc_step(32'(crc_reg), 16'(shreg[DATA_W-1 -: STEP]),
                                     32'(POLY), CRC_W, STEP));
        rot        = {shreg, shreg} << STEP;
        shreg_next = rot[2*DATA_W-1 -: DATA_W];
    end

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            crc_reg   <= '0;
            rx_crc    <= '0;
            mode_r    <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            crc_out   <= '0;
            crc_ok    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg   <= data_in[DATA_W+CRC_W-1 -: DATA_W];
                        rx_crc  <= data_in[CRC_W-1:0];
                        mode_r  <= mode;
                        crc_reg <= INIT;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    crc_reg <= crc_next;
                    shreg   <= shreg_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        data_out  <= {shreg_next, crc_next};
                        crc_out   <= crc_next;
                        crc_ok    <= mode_r ? (crc_next == rx_crc) : 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_gen_param.sv
// Directed bench for crc_gen_param: known "123456789" vectors, back-pressure,
// reset abort, multi-STEP latency and a randomised 176-bit run.
module tb_crc_gen_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    localparam logic [71:0] MSG = 72'h313233343536373839;

    logic        a_valid, a_ready, a_mode, a_ovalid, a_oready, a_ok, a_busy;
    logic [87:0] a_din, a_dout;
    logic [15:0] a_crc;

    logic        f_valid, f_mode, f_oready;
    logic [87:0] f_din;
    logic        b_ready, b_ovalid, b_ok, b_busy;
    logic        c_ready, c_ovalid, c_ok, c_busy;
    logic        d_ready, d_ovalid, d_ok, d_busy;
    logic [87:0] b_dout, c_dout, d_dout;
    logic [15:0] b_crc, c_crc, d_crc;

    logic         r_valid, r_ready, r_mode, r_ovalid, r_oready, r_ok, r_busy;
    logic [191:0] r_din, r_dout;
    logic [15:0]  r_crc;

    int nchk = 0;
    int nerr = 0;
    int lat_a, lat_b, lat_c, lat_d;
    logic         saw;
    logic [175:0] pl;
    logic [15:0]  ex, rx, cap_c;
    logic [191:0] cap_d;
    logic         md, exok, cap_ok, bad_busy, unstable, got, done;

    crc_gen_param #(.DATA_W(72), .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .STEP(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .mode(a_mode),
        .data_in(a_din), .out_valid(a_ovalid), .out_ready(a_oready), .data_out(a_dout),
        .crc_out(a_crc), .crc_ok(a_ok), .busy(a_busy));

    crc_gen_param #(.DATA_W(72), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .STEP(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(f_valid), .in_ready(b_ready), .mode(f_mode),
        .data_in(f_din), .out_valid(b_ovalid), .out_ready(f_oready), .data_out(b_dout),
        .crc_out(b_crc), .crc_ok(b_ok), .busy(b_busy));

    crc_gen_param #(.DATA_W(72), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .STEP(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(f_valid), .in_ready(c_ready), .mode(f_mode),
        .data_in(f_din), .out_valid(c_ovalid), .out_ready(f_oready), .data_out(c_dout),
        .crc_out(c_crc), .crc_ok(c_ok), .busy(c_busy));

    crc_gen_param #(.DATA_W(72), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .STEP(8)) u_d (
        .clk(clk), .rst(rst), .in_valid(f_valid), .in_ready(d_ready), .mode(f_mode),
        .data_in(f_din), .out_valid(d_ovalid), .out_ready(f_oready), .data_out(d_dout),
        .crc_out(d_crc), .crc_ok(d_ok), .busy(d_busy));

    crc_gen_param u_r (
        .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(r_ready), .mode(r_mode),
        .data_in(r_din), .out_valid(r_ovalid), .out_ready(r_oready), .data_out(r_dout),
        .crc_out(r_crc), .crc_ok(r_ok), .busy(r_busy));

    // Bit-serial reference: MSB-first CRC-16 with polynomial 0x1021.
    function automatic logic [15:0] ref_crc(input logic [175:0] d, input int nbits,
                                            input logic [15:0] init);
        logic [15:0] c;
        logic        fb;
        c = init;
        for (int i = nbits - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [87:0] din, input logic m);
        a_din   = din;
        a_mode  = m;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (a_ovalid) begin
                lat = j;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_mode = 1'b0; a_oready = 1'b0; a_din = '0;
        f_valid = 1'b0; f_mode = 1'b0; f_oready = 1'b0; f_din = '0;
        r_valid = 1'b0; r_mode = 1'b0; r_oready = 1'b0; r_din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", a_ready, 0);
        chk("rst_out_valid", a_ovalid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_data_out", a_dout, 0);
        chk("rst_crc_out", a_crc, 0);
        chk("rst_crc_ok", a_ok, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", a_ready, 1);

        // INIT=FFFF across STEP 1/4/8
        f_din = {MSG, 16'h0000}; f_mode = 1'b0; f_oready = 1'b0; f_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f_valid = 1'b0;
        lat_b = 0; lat_c = 0; lat_d = 0;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            if (b_ovalid && lat_b == 0) lat_b = j;
            if (c_ovalid && lat_c == 0) lat_c = j;
            if (d_ovalid && lat_d == 0) lat_d = j;
        end
        chk("lat_step1", lat_b, 72);
        chk("lat_step4", lat_c, 18);
        chk("lat_step8", lat_d, 9);
        chk("crc_step1_ffff", b_crc, 16'h29B1);
        chk("crc_step4_ffff", c_crc, 16'h29B1);
        chk("crc_step8_ffff", d_crc, 16'h29B1);
        chk("dout_step1_ffff", b_dout, {MSG, 16'h29B1});
        f_oready = 1'b1;
        @(negedge clk);
        chk("step1_idle_after_accept", b_busy, 0);

        // Generate mode, INIT=0
        a_oready = 1'b0;
        send_a({MSG, 16'h0000}, 1'b0);
        wait_a(lat_a);
        chk("gen_latency", lat_a, 9);
        chk("gen_crc_out", a_crc, 16'h31C3);
        chk("gen_data_out", a_dout, {MSG, 16'h31C3});
        chk("gen_crc_ok", a_ok, 1);
        chk("gen_done_busy", a_busy, 1);
        chk("gen_done_in_ready", a_ready, 0);

        // Back-pressure with a pending check-mode word on the input
        a_din = {MSG, 16'h31C3}; a_mode = 1'b1; a_valid = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("bp_out_valid", a_ovalid, 1);
            chk("bp_data_out", a_dout, {MSG, 16'h31C3});
            chk("bp_crc_out", a_crc, 16'h31C3);
            chk("bp_in_ready", a_ready, 0);
        end
        a_oready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", a_ovalid, 0);
        chk("bp_release_busy", a_busy, 0);
        chk("bp_release_in_ready", a_ready, 1);
        chk("bp_release_crc_hold", a_crc, 16'h31C3);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        chk("bp_next_accepted", a_busy, 1);
        wait_a(lat_a);
        chk("chk_latency", lat_a, 9);
        chk("chk_crc_ok_good", a_ok, 1);
        chk("chk_crc_out_good", a_crc, 16'h31C3);
        @(negedge clk);

        // Single-bit payload corruption
        send_a({MSG ^ 72'h1, 16'h31C3}, 1'b1);
        wait_a(lat_a);
        chk("chk_latency_bad", lat_a, 9);
        chk("chk_crc_ok_bad", a_ok, 0);
        chk("chk_crc_out_bad", a_crc, ref_crc({104'h0, MSG ^ 72'h1}, 72, 16'h0000));
        @(negedge clk);

        // Reset during RUN cycle 4
        send_a({MSG, 16'h0000}, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", a_busy, 0);
        chk("abort_out_valid", a_ovalid, 0);
        chk("abort_data_out", a_dout, 0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (a_ovalid) saw = 1'b1;
        end
        chk("abort_no_out_valid", saw, 0);

        // rst and in_valid together: rst wins
        rst = 1'b1; a_valid = 1'b1; a_din = {MSG, 16'h0000}; a_mode = 1'b0;
        @(negedge clk);
        rst = 1'b0; a_valid = 1'b0;
        chk("rst_beats_valid", a_busy, 0);

        send_a({MSG, 16'h0000}, 1'b0);
        wait_a(lat_a);
        chk("post_abort_latency", lat_a, 9);
        chk("post_abort_crc", a_crc, 16'h31C3);
        @(negedge clk);

        // Default instance, random words and random out_ready
        for (int w = 0; w < 1000; w++) begin
            pl   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
            ex   = ref_crc(pl, 176, 16'h0000);
            md   = 1'($urandom_range(0, 1));
            rx   = ($urandom_range(0, 1) != 0) ? ex : 16'($urandom());
            exok = md ? (rx == ex) : 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r_din = {pl, rx}; r_mode = md; r_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            r_valid = 1'b0;
            bad_busy = 1'b0; unstable = 1'b0; got = 1'b0; done = 1'b0;
            cap_d = '0; cap_c = '0; cap_ok = 1'b0;
            for (int cy = 0; cy < 200 && !done; cy++) begin
                @(negedge clk);
                if (!r_busy) bad_busy = 1'b1;
                if (r_ovalid) begin
                    if (!got) begin
                        got = 1'b1; cap_d = r_dout; cap_c = r_crc; cap_ok = r_ok;
                    end else if (r_dout !== cap_d || r_crc !== cap_c || r_ok !== cap_ok) begin
                        unstable = 1'b1;
                    end
                    r_oready = ($urandom_range(0, 2) == 0);
                    if (r_oready) begin
                        @(negedge clk);
                        if (r_busy || r_ovalid) bad_busy = 1'b1;
                        r_oready = 1'b0;
                        done = 1'b1;
                    end
                end else begin
                    r_oready = 1'($urandom_range(0, 1));
                end
            end
            chk("rnd_done", done, 1);
            chk("rnd_crc_out", cap_c, ex);
            chk("rnd_data_out", cap_d, {pl, ex});
            chk("rnd_crc_ok", cap_ok, exok);
            chk("rnd_busy", bad_busy, 0);
            chk("rnd_stable", unstable, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
